// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared slice-order constants and width helper for the FIFO family
package fifo_pkg;

  localparam int ORDER_LSB_FIRST = 0;
  localparam int ORDER_MSB_FIRST = 1;

  // Pointer and counter widths; returns 0 for n <= 1, callers clamp as needed.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_unpack.sv
// rtl/fifo_unpack.sv - pops FWFT FIFO words and emits them as RATIO narrower stream beats
module fifo_unpack
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int OSIZE     = 8,
  parameter int MSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DSIZE-1:0] RDATA,
  input  logic             REMPTY,
  output logic             RINC,
  output logic [OSIZE-1:0] ODATA,
  output logic             OVALID,
  input  logic             OREADY,
  output logic             OLAST
);

  localparam int RATIO = DSIZE / OSIZE;
  localparam int IW    = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
  localparam logic [IW-1:0] IDX_LAST = IW'(RATIO - 1);

  generate
    if (OSIZE < 1 || DSIZE % OSIZE != 0) begin : g_bad_ratio
      $fatal(1, "fifo_unpack: DSIZE must be a positive multiple of OSIZE");
    end
  endgenerate

  logic [DSIZE-1:0] word;
  logic             full;
  logic [IW-1:0]    idx;
  logic             last;
  logic             fire;
  logic             free;
  int               sel;

  assign last   = (idx == IDX_LAST);
  // Outputs are forced quiet while RST is high so a held word cannot leak a beat.
  assign OVALID = full & ~RST;
  assign OLAST  = OVALID & last;
  assign fire   = OVALID & OREADY;
  assign free   = ~full | (fire & last);
  assign RINC   = free & ~REMPTY & ~RST;

  always_comb begin
    sel   = (MSB_FIRST == ORDER_MSB_FIRST) ? (RATIO - 1 - int'(idx)) : int'(idx);
    ODATA = '0;
    if (!RST) begin
      for (int s = 0; s < RATIO; s++) begin
        if (sel == s) ODATA = word[s*OSIZE +: OSIZE];
      end
    end
  end

  // A pop always wins: it covers both the first load and the back-to-back reload.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word <= '0;
      full <= 1'b0;
      idx  <= '0;
    end else if (RINC) begin
      word <= RDATA;
      full <= 1'b1;
      idx  <= '0;
    end else if (fire) begin
      if (last) full <= 1'b0;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
// tb/tb_fifo_unpack.sv - scoreboard bench for fifo_unpack (LSB-first, MSB-first, RATIO=1)
module tb_fifo_unpack;
  import fifo_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rdata;
  logic        rempty;
  logic        oready;
  logic [1:0]  cur;

  logic       rst_l, rst_m, rst_r, re_l, re_m, re_r;
  logic       rinc_l, rinc_m, rinc_r, ov_l, ov_m, ov_r, ol_l, ol_m, ol_r;
  logic [7:0] od_l, od_m, od_r;
  logic       o_rinc, o_ov, o_ol;
  logic [7:0] o_od;

  logic       s_rinc, s_ov, s_ol;
  logic [7:0] s_od;

  logic [31:0] fifo_q[$];
  beat_t       exp_q[$];
  int          tests = 0;
  int          failed = 0;
  int          rinc_cnt = 0;
  bit          rdy_pat[12];
  bit          rinc_pat[12];

  always #5 clk = ~clk;

  assign rst_l = (cur == 2'd0) ? rst : 1'b1;
  assign rst_m = (cur == 2'd1) ? rst : 1'b1;
  assign rst_r = (cur == 2'd2) ? rst : 1'b1;
  assign re_l  = (cur == 2'd0) ? rempty : 1'b1;
  assign re_m  = (cur == 2'd1) ? rempty : 1'b1;
  assign re_r  = (cur == 2'd2) ? rempty : 1'b1;

  fifo_unpack #(.DSIZE(32), .OSIZE(8), .MSB_FIRST(ORDER_LSB_FIRST)) u_lsb (
    .CLK(clk), .RST(rst_l), .RDATA(rdata), .REMPTY(re_l), .RINC(rinc_l),
    .ODATA(od_l), .OVALID(ov_l), .OREADY(oready), .OLAST(ol_l));

  fifo_unpack #(.DSIZE(32), .OSIZE(8), .MSB_FIRST(ORDER_MSB_FIRST)) u_msb (
    .CLK(clk), .RST(rst_m), .RDATA(rdata), .REMPTY(re_m), .RINC(rinc_m),
    .ODATA(od_m), .OVALID(ov_m), .OREADY(oready), .OLAST(ol_m));

  fifo_unpack #(.DSIZE(8), .OSIZE(8), .MSB_FIRST(ORDER_LSB_FIRST)) u_r1 (
    .CLK(clk), .RST(rst_r), .RDATA(rdata[7:0]), .REMPTY(re_r), .RINC(rinc_r),
    .ODATA(od_r), .OVALID(ov_r), .OREADY(oready), .OLAST(ol_r));

  always_comb begin
    o_rinc = rinc_l; o_ov = ov_l; o_ol = ol_l; o_od = od_l;
    if (cur == 2'd1) begin
      o_rinc = rinc_m; o_ov = ov_m; o_ol = ol_m; o_od = od_m;
    end else if (cur == 2'd2) begin
      o_rinc = rinc_r; o_ov = ov_r; o_ol = ol_r; o_od = od_r;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 32'h0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [31:0] w, input int ratio, input bit msb);
    beat_t b;
    int    s;
    fifo_q.push_back(w);
    for (int i = 0; i < ratio; i++) begin
      s      = msb ? (ratio - 1 - i) : i;
      b.d    = 8'((w >> (8 * s)) & 32'hFF);
      b.last = (i == ratio - 1);
      exp_q.push_back(b);
    end
    refresh();
  endtask

  // One cycle: sample at the falling edge, apply the FIFO pop just after the rising edge.
  task automatic step();
    beat_t       e;
    logic [31:0] dump;
    @(negedge clk);
    s_rinc = o_rinc; s_ov = o_ov; s_ol = o_ol; s_od = o_od;
    if (s_rinc) rinc_cnt++;
    chk("rinc_while_empty", {31'b0, s_rinc & rempty}, 32'd0);
    if (s_ov && oready) begin
      chk("sb_pending", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", {24'b0, s_od}, {24'b0, e.d});
        chk("beat_last", {31'b0, s_ol}, {31'b0, e.last});
      end
    end
    @(posedge clk);
    #1;
    if (s_rinc && fifo_q.size() != 0) dump = fifo_q.pop_front();
    refresh();
  endtask

  initial begin
    beat_t drop;
    cur = 2'd0; rst = 1'b1; oready = 1'b0;
    refresh();

    // Reset state
    step(); step();
    chk("rst_ovalid", {31'b0, s_ov}, 32'd0);
    chk("rst_olast", {31'b0, s_ol}, 32'd0);
    chk("rst_rinc", {31'b0, s_rinc}, 32'd0);
    chk("rst_odata", {24'b0, s_od}, 32'd0);

    // Single word, free-flowing
    rst = 1'b0; oready = 1'b1; rinc_cnt = 0;
    push_word(32'hDDCCBBAA, 4, 1'b0);
    step();
    chk("t1_pop_rinc", {31'b0, s_rinc}, 32'd1);
    chk("t1_pop_ovalid", {31'b0, s_ov}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_ovalid", {31'b0, s_ov}, 32'd1);
    end
    step();
    chk("t1_idle_ovalid", {31'b0, s_ov}, 32'd0);
    chk("t1_rinc_count", rinc_cnt, 32'd1);
    chk("t1_drained", exp_q.size(), 32'd0);

    // Three words back to back
    push_word(32'h03020100, 4, 1'b0);
    push_word(32'h07060504, 4, 1'b0);
    push_word(32'h0B0A0908, 4, 1'b0);
    step();
    chk("t2_pop_rinc", {31'b0, s_rinc}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t2_ovalid", {31'b0, s_ov}, 32'd1);
      chk("t2_rinc", {31'b0, s_rinc}, {31'b0, (k == 3 || k == 7)});
    end
    step();
    chk("t2_idle_ovalid", {31'b0, s_ov}, 32'd0);
    chk("t2_drained", exp_q.size(), 32'd0);

    // Backpressure with a second word waiting behind
    rdy_pat  = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    rinc_pat = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    push_word(32'hDDCCBBAA, 4, 1'b0);
    push_word(32'h44332211, 4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      oready = rdy_pat[k];
      step();
      chk("t3_rinc", {31'b0, s_rinc}, {31'b0, rinc_pat[k]});
      if (k == 2 || k == 3) begin
        chk("t3_stall_data", {24'b0, s_od}, 32'hBB);
        chk("t3_stall_valid", {31'b0, s_ov}, 32'd1);
      end
    end
    chk("t3_idle_ovalid", {31'b0, s_ov}, 32'd0);
    chk("t3_drained", exp_q.size(), 32'd0);

    // Reset mid-word discards CC/DD
    oready = 1'b1;
    push_word(32'hDDCCBBAA, 4, 1'b0);
    push_word(32'h55667788, 4, 1'b0);
    step(); step(); step();
    drop = exp_q.pop_front();
    drop = exp_q.pop_front();
    rst = 1'b1;
    step();
    chk("t4_rst_ovalid", {31'b0, s_ov}, 32'd0);
    chk("t4_rst_rinc", {31'b0, s_rinc}, 32'd0);
    rst = 1'b0;
    step();
    chk("t4_post_ovalid", {31'b0, s_ov}, 32'd0);
    chk("t4_post_rinc", {31'b0, s_rinc}, 32'd1);
    for (int k = 0; k < 5; k++) step();
    chk("t4_idle_ovalid", {31'b0, s_ov}, 32'd0);
    chk("t4_drained", exp_q.size(), 32'd0);

    // MSB-first instance
    cur = 2'd1; rst = 1'b1;
    step(); step();
    rst = 1'b0; rinc_cnt = 0;
    push_word(32'h11223344, 4, 1'b1);
    for (int k = 0; k < 6; k++) step();
    chk("t5_idle_ovalid", {31'b0, s_ov}, 32'd0);
    chk("t5_rinc_count", rinc_cnt, 32'd1);
    chk("t5_drained", exp_q.size(), 32'd0);

    // RATIO=1 instance
    cur = 2'd2; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    push_word(32'h5A, 1, 1'b0);
    push_word(32'hA5, 1, 1'b0);
    step();
    chk("t6_pop_rinc", {31'b0, s_rinc}, 32'd1);
    step();
    chk("t6_b0_olast", {31'b0, s_ol}, 32'd1);
    chk("t6_b0_reload", {31'b0, s_rinc}, 32'd1);
    step();
    chk("t6_b1_olast", {31'b0, s_ol}, 32'd1);
    chk("t6_b1_rinc", {31'b0, s_rinc}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_empty_ovalid", {31'b0, s_ov}, 32'd0);
      chk("t6_empty_rinc", {31'b0, s_rinc}, 32'd0);
    end
    chk("t6_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
